// File: rtl/preproc_pkg.sv
// Shared constants and types for the grayscale tile packing stage.
package preproc_pkg;
  localparam int TILE_N  = 8;
  localparam int PIX_W   = 8;
  localparam int RGB_W   = 24;
  localparam int GRAY_KR = 77;
  localparam int GRAY_KG = 150;
  localparam int GRAY_KB = 29;
  localparam int R_OFS   = 16;
  localparam int G_OFS   = 8;
  localparam int B_OFS   = 0;

  typedef logic [TILE_N*PIX_W-1:0] gray_row_t;

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_SEND = 1'b1
  } out_state_e;
endpackage

// File: rtl/rgb2gray_lane.sv
// Combinational RGB888 to 8-bit gray: weighted sum truncated to 16 bits, top byte kept.
module rgb2gray_lane import preproc_pkg::*; (
  input  logic [RGB_W-1:0] rgb,
  output logic [7:0]       gray
);
  logic [15:0] wsum;

  always_comb begin
    wsum = 16'(GRAY_KR) * 16'(rgb[R_OFS +: 8])
         + 16'(GRAY_KG) * 16'(rgb[G_OFS +: 8])
         + 16'(GRAY_KB) * 16'(rgb[B_OFS +: 8]);
  end

  assign gray = wsum[15:8];
endmodule

// File: rtl/gray_tile_packer.sv
// Converts 8-pixel RGB rows to gray, packs 8 rows per tile into a ping-pong buffer and
// streams each tile as 8 AXIS beats with its mean; tile visible 3 cycles after row 7.
module gray_tile_packer #(
  parameter int LANES = 8,
  parameter int PIX_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [LANES*3*PIX_W-1:0] i_row_data,
  input  logic                     i_row_valid,
  output logic                     o_in_ready,
  output logic [LANES*PIX_W-1:0]   m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [PIX_W-1:0]         o_tile_mean,
  output logic                     o_tile_done,
  output logic                     o_overflow
);
  import preproc_pkg::*;

  logic [LANES-1:0][PIX_W-1:0] lane_gray;
  logic [10:0]                 row_sum;
  logic                        accept;

  logic                        s1_vld;
  gray_row_t                   s1_gray;
  logic [10:0]                 s1_sum;
  logic                        s1_bank;
  logic [2:0]                  s1_row;

  logic [2:0]                  in_row, in_row_nxt;
  logic                        in_bank, in_bank_nxt;
  logic [1:0]                  busy, busy_nxt, filled;
  logic [1:0][13:0]            acc;
  logic                        ready_nxt;
  gray_row_t                   bank [2][TILE_N];

  out_state_e                  state, state_nxt;
  logic [2:0]                  beat, beat_nxt;
  logic                        rd_bank, rd_bank_nxt;
  logic                        tile_fire;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    rgb2gray_lane u_lane (
      .rgb  (i_row_data[RGB_W*k +: RGB_W]),
      .gray (lane_gray[k])
    );
  end

  always_comb begin
    row_sum = '0;
    for (int k = 0; k < LANES; k++) row_sum = row_sum + 11'(lane_gray[k]);
  end

  assign accept = i_row_valid && o_in_ready;

  // A bank is claimed at row 0 and stays ours until row 7, so only a fresh tile needs a free bank.
  always_comb begin
    in_row_nxt  = in_row;
    in_bank_nxt = in_bank;
    busy_nxt    = busy;
    if (tile_fire) busy_nxt[rd_bank] = 1'b0;
    if (accept) begin
      if (in_row == 3'd0) busy_nxt[in_bank] = 1'b1;
      in_row_nxt = in_row + 3'd1;
      if (in_row == 3'd7) in_bank_nxt = ~in_bank;
    end
    ready_nxt = (in_row_nxt != 3'd0) || !busy_nxt[in_bank_nxt];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      s1_vld     <= 1'b0;
      s1_gray    <= '0;
      s1_sum     <= '0;
      s1_bank    <= 1'b0;
      s1_row     <= '0;
      in_row     <= '0;
      in_bank    <= 1'b0;
      busy       <= '0;
      filled     <= '0;
      acc        <= '0;
      o_in_ready <= 1'b1;
      o_overflow <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_gray <= lane_gray;
        s1_sum  <= row_sum;
        s1_bank <= in_bank;
        s1_row  <= in_row;
      end
      in_row     <= in_row_nxt;
      in_bank    <= in_bank_nxt;
      busy       <= busy_nxt;
      o_in_ready <= ready_nxt;
      if (i_row_valid && !o_in_ready) o_overflow <= 1'b1;
      // Fill and release always target different banks, so these never collide.
      if (s1_vld) begin
        acc[s1_bank] <= acc[s1_bank] + 14'(s1_sum);
        if (s1_row == 3'd7) filled[s1_bank] <= 1'b1;
      end
      if (tile_fire) begin
        acc[rd_bank]    <= '0;
        filled[rd_bank] <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (s1_vld) bank[s1_bank][s1_row] <= s1_gray;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state       <= OUT_IDLE;
      beat        <= '0;
      rd_bank     <= 1'b0;
      o_tile_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      beat        <= beat_nxt;
      rd_bank     <= rd_bank_nxt;
      o_tile_done <= tile_fire;
    end
  end

  always_comb begin
    state_nxt     = state;
    beat_nxt      = beat;
    rd_bank_nxt   = rd_bank;
    tile_fire     = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    o_tile_mean   = '0;
    case (state)
      OUT_IDLE: begin
        if (filled[rd_bank]) begin
          state_nxt = OUT_SEND;
          beat_nxt  = '0;
        end
      end
      OUT_SEND: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = bank[rd_bank][beat];
        m_axis_tlast  = (beat == 3'd7);
        o_tile_mean   = acc[rd_bank][13:6];
        if (m_axis_tready) begin
          beat_nxt = beat + 3'd1;
          if (beat == 3'd7) begin
            tile_fire   = 1'b1;
            rd_bank_nxt = ~rd_bank;
            state_nxt   = OUT_IDLE;
          end
        end
      end
      default: state_nxt = OUT_IDLE;
    endcase
  end
endmodule

// File: tb/tb_gray_tile_packer.sv
// Bench for gray_tile_packer: directed tables and sequences plus random traffic against a queue-based model.
module tb_gray_tile_packer;
  logic         i_clk = 1'b0;
  logic         i_rst = 1'b0;
  logic [191:0] i_row_data = '0;
  logic         i_row_valid = 1'b0;
  logic         o_in_ready;
  logic [63:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic         m_axis_tlast;
  logic [7:0]   o_tile_mean;
  logic         o_tile_done;
  logic         o_overflow;

  gray_tile_packer dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_row_data    (i_row_data),
    .i_row_valid   (i_row_valid),
    .o_in_ready    (o_in_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .o_tile_mean   (o_tile_mean),
    .o_tile_done   (o_tile_done),
    .o_overflow    (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [23:0] rgb;
    logic [7:0]  gray;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: tiles as queues of expected beats, banks as a simple ownership count.
  logic [63:0] q_beat[$];
  logic [7:0]  q_mean[$];
  logic [63:0] pend[$];
  int          m_partial, m_owned, m_beat, m_sum;
  logic        m_ready, m_ovf, m_done;
  logic        p_stall;
  logic [63:0] p_dat;
  logic        p_last;
  logic [7:0]  p_mean;
  logic [63:0] last_dat;
  logic [7:0]  last_mean;
  int          cyc = 0;
  int          first_vld, n_done, row7_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  function automatic logic [63:0] gray_row(input logic [191:0] d);
    logic [63:0] g;
    int r, gg, b;
    g = '0;
    for (int k = 0; k < 8; k++) begin
      r  = int'(d[24*k+16 +: 8]);
      gg = int'(d[24*k+8 +: 8]);
      b  = int'(d[24*k +: 8]);
      g[8*k +: 8] = 8'((77*r + 150*gg + 29*b) / 256);
    end
    return g;
  endfunction

  function automatic int row_total(input logic [63:0] g);
    int s;
    s = 0;
    for (int k = 0; k < 8; k++) s += int'(g[8*k +: 8]);
    return s;
  endfunction

  task automatic model_reset();
    q_beat.delete(); q_mean.delete(); pend.delete();
    m_partial = 0; m_owned = 0; m_beat = 0; m_sum = 0;
    m_ready = 1'b1; m_ovf = 1'b0; m_done = 1'b0;
    p_stall = 1'b0; first_vld = -1; n_done = 0;
  endtask

  task automatic cycle(input logic vld, input logic [191:0] dat, input logic rdy);
    logic fire_last;
    logic [63:0] g;
    fire_last = 1'b0;
    @(negedge i_clk);
    i_row_valid = vld; i_row_data = dat; m_axis_tready = rdy;
    #1;
    cyc++;
    chk("in_ready", 64'(o_in_ready), 64'(m_ready));
    chk("overflow", 64'(o_overflow), 64'(m_ovf));
    chk("tile_done", 64'(o_tile_done), 64'(m_done));
    if (o_tile_done) n_done++;
    if (p_stall) begin
      chk("hold_valid", 64'(m_axis_tvalid), 64'(1));
      chk("hold_data", m_axis_tdata, p_dat);
      chk("hold_last", 64'(m_axis_tlast), 64'(p_last));
      chk("hold_mean", 64'(o_tile_mean), 64'(p_mean));
    end
    if (m_axis_tvalid && first_vld < 0) first_vld = cyc;
    if (m_axis_tvalid && rdy) begin
      last_dat = m_axis_tdata; last_mean = o_tile_mean;
      chk("beat_queued", 64'(q_beat.size() != 0), 64'(1));
      if (q_beat.size() != 0) begin
        chk("tdata", m_axis_tdata, q_beat.pop_front());
        chk("tlast", 64'(m_axis_tlast), 64'(m_beat == 7));
        chk("mean", 64'(o_tile_mean), 64'(q_mean[0]));
        m_beat++;
        if (m_beat == 8) begin
          m_beat = 0;
          void'(q_mean.pop_front());
          fire_last = 1'b1;
          m_owned--;
        end
      end
    end
    p_stall = m_axis_tvalid && !rdy;
    p_dat = m_axis_tdata; p_last = m_axis_tlast; p_mean = o_tile_mean;
    if (vld) begin
      if (m_ready) begin
        if (m_partial == 0) m_owned++;
        g = gray_row(dat);
        pend.push_back(g);
        m_sum += row_total(g);
        m_partial++;
        if (m_partial == 8) begin
          foreach (pend[i]) q_beat.push_back(pend[i]);
          q_mean.push_back(8'(m_sum / 64));
          pend.delete(); m_partial = 0; m_sum = 0;
        end
      end else m_ovf = 1'b1;
    end
    m_done = fire_last;
    m_ready = (m_partial != 0) || (m_owned < 2);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b0; i_row_valid = 1'b0; m_axis_tready = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("rst_tdata", m_axis_tdata, 64'(0));
    chk("rst_tlast", 64'(m_axis_tlast), 64'(0));
    chk("rst_mean", 64'(o_tile_mean), 64'(0));
    chk("rst_done", 64'(o_tile_done), 64'(0));
    chk("rst_overflow", 64'(o_overflow), 64'(0));
    chk("rst_in_ready", 64'(o_in_ready), 64'(1));
    model_reset();
    i_rst = 1'b1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1);
    chk("drained", 64'(q_beat.size()), 64'(0));
  endtask

  initial begin
    vec_t tbl[8];
    logic [191:0] d;
    int d0;
    tbl[0] = '{24'hFF0000, 8'd76};
    tbl[1] = '{24'h00FF00, 8'd149};
    tbl[2] = '{24'h0000FF, 8'd28};
    tbl[3] = '{24'hFFFFFF, 8'd255};
    tbl[4] = '{24'h000000, 8'd0};
    tbl[5] = '{24'h808080, 8'd128};
    tbl[6] = '{24'h102030, 8'd29};
    tbl[7] = '{24'hFF8000, 8'd151};

    model_reset();
    do_reset();

    // White tile: latency, data, mean, single done pulse
    for (int r = 0; r < 8; r++) begin
      cycle(1'b1, {8{24'hFFFFFF}}, 1'b1);
      if (r == 7) row7_cyc = cyc;
    end
    drain(16);
    chk("first_tvalid_latency", 64'(first_vld - row7_cyc), 64'(3));
    chk("done_pulses", 64'(n_done), 64'(1));
    chk("white_mean", 64'(last_mean), 64'hFF);
    chk("white_data", last_dat, 64'hFFFF_FFFF_FFFF_FFFF);

    // Table of pixel colours across the lanes
    for (int k = 0; k < 8; k++) d[24*k +: 24] = tbl[k].rgb;
    for (int r = 0; r < 8; r++) cycle(1'b1, d, 1'b1);
    drain(16);
    for (int k = 0; k < 8; k++) chk($sformatf("table_lane%0d", k), 64'(last_dat[8*k +: 8]), 64'(tbl[k].gray));

    // Ramp tile: pixel value r*8+k
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) d[24*k +: 24] = {3{8'(r*8 + k)}};
      cycle(1'b1, d, 1'b1);
    end
    drain(16);
    chk("ramp_mean", 64'(last_mean), 64'(31));
    chk("ramp_last_lane0", 64'(last_dat[7:0]), 64'(56));

    // Toggling tready
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) d[24*k +: 24] = {3{8'(200 - r*8 - k)}};
      cycle(1'b1, d, 1'(r % 2));
    end
    for (int i = 0; i < 30; i++) cycle(1'b0, '0, 1'(i % 2));
    chk("toggle_drained", 64'(q_beat.size()), 64'(0));

    // Both banks full, 17th row dropped
    d0 = n_done;
    for (int r = 0; r < 17; r++) cycle(1'b1, {8{{3{8'(r * 13)}}}}, 1'b0);
    cycle(1'b0, '0, 1'b0);
    chk("ovf_set", 64'(o_overflow), 64'(1));
    chk("full_ready_low", 64'(o_in_ready), 64'(0));
    drain(30);
    chk("two_tiles_done", 64'(n_done - d0), 64'(2));

    // Reset in the middle of a tile
    do_reset();
    for (int r = 0; r < 8; r++) cycle(1'b1, {8{{3{8'(100 + r)}}}}, 1'b0);
    for (int r = 0; r < 4; r++) cycle(1'b1, {8{{3{8'(50 + r)}}}}, 1'b1);
    for (int i = 0; i < 20 && m_beat != 3; i++) cycle(1'b0, '0, 1'b1);
    chk("reached_beat3", 64'(m_beat), 64'(3));
    do_reset();
    for (int r = 0; r < 8; r++) cycle(1'b1, {8{{3{8'(10 + r)}}}}, 1'b1);
    drain(16);
    chk("clean_tile_done", 64'(n_done), 64'(1));

    // Random traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      for (int w = 0; w < 6; w++) d[32*w +: 32] = $urandom;
      cycle($urandom_range(0, 9) < 6, d, 1'($urandom_range(0, 1)));
    end
    drain(40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
